uart_tx_peripheral: RTL and testbench

Memory-mapped UART transmitter on the CPU data-memory bus. It sits directly downstream of the MEM stage and consumes its store traffic: address, store data and write/read strobes. The block has a TX data register with a byte FIFO and a status register, and it serialises bytes onto a single tx line as 8N1 frames. It is the first peripheral on the bus.

---
 rtl/uart_tx_peripheral.sv | 126 ++++++++++++
 tb/tb_uart_tx_peripheral.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/uart_tx_peripheral.sv
// uart_tx_peripheral: memory-mapped 8N1 UART transmitter with byte FIFO and status register
module uart_tx_peripheral #(
    parameter int          CLOCK_FREQ   = 27000000,
    parameter int          BAUD_RATE    = 115200,
    parameter int          FIFO_DEPTH   = 8,
    parameter logic [31:0] BASE_ADDRESS = 32'h0000_1000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic [31:0] input_data,
    input  logic        mem_write,
    input  logic        mem_read,
    output logic [31:0] output_data,
    output logic        selected,
    output logic        tx,
    output logic        tx_busy
);
    localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_next;
    logic [BW-1:0] baud_cnt, baud_next;
    logic [2:0]    bit_idx, bit_next;
    logic [7:0]    shift, shift_next;
    logic [7:0]    fifo [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic          overflow, fifo_full, fifo_empty, hit, wr_data, wr_status;
    logic          push, pop, baud_done, tx_next;
    logic [31:0]   status;
    logic          unused;

    assign unused      = ^{address[1:0], input_data[31:8]};
    assign hit         = address[31:3] == BASE_ADDRESS[31:3];
    assign selected    = hit;
    assign wr_data     = hit && mem_write && !address[2];
    assign wr_status   = hit && mem_write && address[2];
    assign fifo_full   = count == CW'(FIFO_DEPTH);
    assign fifo_empty  = count == '0;
    assign push        = wr_data && !fifo_full;
    assign baud_done   = baud_cnt == BW'(CLKS_PER_BIT - 1);
    assign tx_busy     = state != IDLE;
    assign status      = {24'b0, 4'(count), overflow, tx_busy, fifo_empty, fifo_full};
    assign output_data = (hit && mem_read && address[2]) ? status : '0;

    always_comb begin
        state_next = state;
        baud_next  = baud_cnt;
        bit_next   = bit_idx;
        shift_next = shift;
        pop        = 1'b0;
        case (state)
            IDLE: if (!fifo_empty) begin
                pop        = 1'b1;
                shift_next = fifo[rd_ptr];
                baud_next  = '0;
                state_next = START;
            end
            START: if (baud_done) begin
                baud_next  = '0;
                bit_next   = '0;
                state_next = DATA;
            end else begin
                baud_next = baud_cnt + 1'b1;
            end
            DATA: if (baud_done) begin
                baud_next  = '0;
                shift_next = {1'b0, shift[7:1]};
                bit_next   = bit_idx + 3'd1;
                state_next = (bit_idx == 3'd7) ? STOP : DATA;
            end else begin
                baud_next = baud_cnt + 1'b1;
            end
            STOP: if (baud_done) begin
                baud_next  = '0;
                pop        = !fifo_empty;
                shift_next = fifo_empty ? shift : fifo[rd_ptr];
                state_next = fifo_empty ? IDLE : START;
            end else begin
                baud_next = baud_cnt + 1'b1;
            end
            default: state_next = IDLE;
        endcase
        // tx is driven from the next state so the registered line changes on the same edge as the FSM
        tx_next = (state_next == START) ? 1'b0 : (state_next == DATA) ? shift_next[0] : 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            tx       <= 1'b1;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            state    <= state_next;
            baud_cnt <= baud_next;
            bit_idx  <= bit_next;
            shift    <= shift_next;
            tx       <= tx_next;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= (push && !pop) ? count + 1'b1 : (pop && !push) ? count - 1'b1 : count;
            if (wr_data && fifo_full)
                overflow <= 1'b1;
            else if (wr_status && input_data[3])
                overflow <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (push)
            fifo[wr_ptr] <= input_data[7:0];
    end
endmodule

// File: tb/tb_uart_tx_peripheral.sv
// tb_uart_tx_peripheral: directed checks of decode, status, FIFO overflow and 8N1 framing
module tb_uart_tx_peripheral;
    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam logic [31:0] STAT = BASE + 32'd4;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] address = '0;
    logic [31:0] input_data = '0;
    logic        mem_write = 1'b0;
    logic        mem_read = 1'b0;
    logic [31:0] output_data;
    logic        selected, tx, tx_busy;
    int          vectors = 0;
    int          miscompares = 0;

    uart_tx_peripheral #(
        .CLOCK_FREQ(8), .BAUD_RATE(1), .FIFO_DEPTH(4), .BASE_ADDRESS(BASE)
    ) dut (
        .clock(clock), .reset(reset), .address(address), .input_data(input_data),
        .mem_write(mem_write), .mem_read(mem_read), .output_data(output_data),
        .selected(selected), .tx(tx), .tx_busy(tx_busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        address    = a;
        input_data = d;
        mem_write  = 1'b1;
        tick();
        mem_write  = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        address  = a;
        mem_read = 1'b1;
        #1;
        check(tag, output_data, exp);
        mem_read = 1'b0;
    endtask

    // Called just after the edge where the start bit begins; returns after the edge ending the stop bit.
    task automatic frame(input string tag, input logic [7:0] b);
        logic lvl;
        for (int i = 0; i < 80; i++) begin
            lvl = (i < 8) ? 1'b0 : (i >= 72) ? 1'b1 : b[(i - 8) / 8];
            check(tag, {30'b0, tx_busy, tx}, {30'b0, 1'b1, lvl});
            tick();
        end
    endtask

    initial begin
        reset = 1'b1;
        #1;
        check("reset_tx", {31'b0, tx}, 32'd1);
        check("reset_busy", {31'b0, tx_busy}, 32'd0);
        repeat (3) tick();
        reset = 1'b0;
        rd("status_after_reset", STAT, 32'h02);
        check("sel_status", {31'b0, selected}, 32'd1);

        wr(BASE, 32'h55);
        check("idle_until_pop", {31'b0, tx}, 32'd1);
        tick();
        frame("frame_55", 8'h55);
        check("busy_fall_55", {30'b0, tx_busy, tx}, 32'b01);

        wr(BASE, 32'hA3);
        wr(BASE, 32'h0F);
        rd("count_in_flight", STAT, 32'h14);
        frame("frame_a3", 8'hA3);
        frame("frame_0f", 8'h0F);
        check("busy_fall_pair", {30'b0, tx_busy, tx}, 32'b01);
        rd("status_drained", STAT, 32'h02);

        wr(BASE, 32'hFF);
        tick();
        tick();
        for (int i = 1; i <= 5; i++) wr(BASE, 32'(i));
        rd("status_overflow", STAT, 32'h4D);
        address    = STAT;
        input_data = 32'h8;
        mem_write  = 1'b1;
        mem_read   = 1'b1;
        #1;
        check("rw_pre_edge", output_data, 32'h4D);
        tick();
        mem_write = 1'b0;
        check("rw_post_edge", output_data, 32'h45);
        mem_read = 1'b0;
        rd("status_low_bits_ignored", BASE + 32'd6, 32'h45);
        rd("data_read_zero", BASE, 32'h0);
        check("sel_data", {31'b0, selected}, 32'd1);

        reset = 1'b1;
        #1;
        reset = 1'b0;
        rd("status_reset2", STAT, 32'h02);
        wr(BASE, 32'h00);
        tick();
        repeat (29) tick();
        check("mid_frame_low", {30'b0, tx_busy, tx}, 32'b10);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_tx", {30'b0, tx_busy, tx}, 32'b01);
        rd("async_reset_status", STAT, 32'h02);
        reset = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            check("no_frame_after_reset", {30'b0, tx_busy, tx}, 32'b01);
        end

        address  = BASE + 32'd8;
        mem_read = 1'b1;
        #1;
        check("miss_selected", {31'b0, selected}, 32'd0);
        check("miss_data", output_data, 32'h0);
        mem_read = 1'b0;
        wr(BASE + 32'd8, 32'h77);
        rd("miss_write_ignored", STAT, 32'h02);
        tick();
        check("miss_no_tx", {30'b0, tx_busy, tx}, 32'b01);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
